// File: rtl/div_seq_if.sv
// Handshake and data bundle for the sequential divider.
// The master issues start with a/b; the slave returns q/r/dz with busy/done.
interface div_seq_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          start;
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic          busy;
    logic          done;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;

    modport master (
        output start, a, b,
        input  busy, done, q, r, dz
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, r, dz
    );
endinterface

// File: rtl/div_seq.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor.
// One quotient bit per cycle, with a start/busy/done handshake.
module div_seq #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic     clk,
    input  logic     rst,
    div_seq_if.slave bus
);
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {IDLE, RUN, ZDIV, DONE} state_t;

    state_t        state_reg, state_next;
    logic [DW-1:0] a_reg;
    logic [VW-1:0] b_reg;
    logic [VW:0]   r_reg;
    logic [CW-1:0] cnt_reg;
    logic [DW-1:0] q_reg;
    logic [VW-1:0] rem_reg;
    logic          dz_reg;

    logic [VW:0]   shifted;
    logic [VW:0]   trial;
    logic          ge;
    logic [VW:0]   r_step;
    logic [DW-1:0] a_step;

    // The partial remainder stays below b, so its top bit is always zero
    // before the shift; that frees room for the incoming dividend bit.
    always_comb begin
        shifted = {r_reg[VW-1:0], a_reg[DW-1]};
        ge      = (shifted >= {1'b0, b_reg});
        trial   = shifted - {1'b0, b_reg};
        r_step  = ge ? trial : shifted;
        a_step  = {a_reg[DW-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (bus.start) state_next = (bus.b != '0) ? RUN : ZDIV;
            RUN:  if (cnt_reg == CW'(1)) state_next = DONE;
            ZDIV: state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            r_reg   <= '0;
            cnt_reg <= '0;
            q_reg   <= '0;
            rem_reg <= '0;
            dz_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_reg   <= bus.a;
                        b_reg   <= bus.b;
                        r_reg   <= '0;
                        cnt_reg <= CW'(DW);
                    end
                end
                RUN: begin
                    a_reg   <= a_step;
                    r_reg   <= r_step;
                    cnt_reg <= cnt_reg - CW'(1);
                    // Results are published only on the final step.
                    if (cnt_reg == CW'(1)) begin
                        q_reg   <= a_step;
                        rem_reg <= r_step[VW-1:0];
                        dz_reg  <= 1'b0;
                    end
                end
                ZDIV: begin
                    q_reg   <= '1;
                    rem_reg <= '1;
                    dz_reg  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_reg != IDLE);
    assign bus.done = (state_reg == DONE);
    assign bus.q    = q_reg;
    assign bus.r    = rem_reg;
    assign bus.dz   = dz_reg;
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: hand-computed quotients/remainders,
// handshake latency, hold behaviour, start-while-busy and mid-op reset.
module tb_div_seq;
    localparam int DW = 8;
    localparam int VW = 4;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    logic [DW-1:0] last_q;
    logic [VW-1:0] last_r;

    div_seq_if #(.DW(DW), .VW(VW)) bus ();

    div_seq #(.DW(DW), .VW(VW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation in the current (IDLE) cycle and follow it to IDLE.
    task automatic run_op(input string tag, input logic [DW-1:0] av, input logic [VW-1:0] bv,
                          input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic edz);
        int k;
        int lat;
        int busy_cnt;
        int exp_lat;
        exp_lat   = (bv == '0) ? 1 : DW;
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        tick();
        bus.start = 1'b0;
        bus.a     = DW'($urandom);
        bus.b     = VW'($urandom);
        k = 0;
        lat = -1;
        busy_cnt = 0;
        while (k < 40 && lat < 0) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                lat = k;
            end else begin
                if (k == 1 && bv != '0) begin
                    chk({tag, "_hold_q"}, bus.q, last_q);
                    chk({tag, "_hold_r"}, bus.r, last_r);
                end
                tick();
                k++;
            end
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_q"}, bus.q, eq);
        chk({tag, "_r"}, bus.r, er);
        chk({tag, "_dz"}, bus.dz, edz);
        chk({tag, "_busy_cycles"}, busy_cnt, exp_lat + 1);
        $display("[TB] op %s a=%0d b=%0d -> q=%0d r=%0d dz=%0d lat=%0d",
                 tag, av, bv, bus.q, bus.r, bus.dz, lat);
        tick();
        chk({tag, "_done_pulse"}, bus.done, 0);
        chk({tag, "_idle"}, bus.busy, 0);
        chk({tag, "_q_held"}, bus.q, eq);
        last_q = eq;
        last_r = er;
    endtask

    initial begin
        int k;
        int ndone;
        tests = 0;
        fails = 0;
        last_q = '0;
        last_r = '0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_q", bus.q, 0);
        chk("reset_r", bus.r, 0);
        chk("reset_dz", bus.dz, 0);
        tick();

        run_op("basic_143_11", 8'd143, 4'd11, 8'd13, 4'd0, 1'b0);
        run_op("chain_54_6", 8'd54, 4'd6, 8'd9, 4'd0, 1'b0);
        run_op("chain_6_3", 8'd6, 4'd3, 8'd2, 4'd0, 1'b0);
        run_op("chain_200_7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
        run_op("dz_77_0", 8'd77, 4'd0, 8'hFF, 4'hF, 1'b1);
        run_op("after_dz_15_15", 8'd15, 4'd15, 8'd1, 4'd0, 1'b0);
        run_op("bnd_255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
        run_op("bnd_0_9", 8'd0, 4'd9, 8'd0, 4'd0, 1'b0);
        run_op("bnd_14_15", 8'd14, 4'd15, 8'd0, 4'd14, 1'b0);

        // start held high across the whole operation with a/b changing
        bus.start = 1'b1;
        bus.a = 8'd100;
        bus.b = 4'd3;
        tick();
        ndone = 0;
        for (k = 0; k < DW + 1; k++) begin
            if (k == 2) begin
                bus.a = 8'd1;
                bus.b = 4'd1;
            end
            if (bus.done) begin
                ndone++;
                chk("held_q", bus.q, 33);
                chk("held_r", bus.r, 1);
            end
            tick();
        end
        chk("held_done_count", ndone, 1);
        chk("held_idle_after", bus.busy, 0);
        $display("[TB] op held_100_3 a=100 b=3 -> q=%0d r=%0d dones=%0d", bus.q, bus.r, ndone);
        bus.start = 1'b0;
        last_q = 8'd33;
        last_r = 4'd1;
        run_op("after_held_1_1", 8'd1, 4'd1, 8'd1, 4'd0, 1'b0);

        // reset on the 4th edge after acceptance
        bus.start = 1'b1;
        bus.a = 8'd143;
        bus.b = 4'd11;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_q", bus.q, 0);
        chk("abort_r", bus.r, 0);
        ndone = 0;
        for (k = 0; k < 12; k++) begin
            if (bus.done) ndone++;
            tick();
        end
        chk("abort_no_done", ndone, 0);
        $display("[TB] op abort_143_11 reset mid-op -> q=%0d r=%0d dones=%0d", bus.q, bus.r, ndone);
        last_q = '0;
        last_r = '0;
        run_op("after_abort_143_11", 8'd143, 4'd11, 8'd13, 4'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
